// File: rtl/rect_grid_store.sv
// Responder-side playfield store: 32x24 grid of 4-bit cell codes with a controller port,
// a registered renderer port, a snack counter and a clearing sweep. Define GRID_BORDER_EN to sweep a ROCK border.
module rect_grid_store #(
  parameter int GRID_SIZE_X = 32,
  parameter int GRID_SIZE_Y = 24,
  parameter int RECT_SHIFT  = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [35:0] rect_write,
  input  logic [31:0] rect_read_addr,
  output logic [3:0]  rect_read_data,
  input  logic        clear_req,
  output logic        busy,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  output logic [3:0]  pix_cell,
  output logic [9:0]  snack_count
);

  localparam int CELLS = GRID_SIZE_X * GRID_SIZE_Y;
  localparam int AW    = $clog2(CELLS);

  localparam logic [3:0] CELL_NULL  = 4'b0000;
  localparam logic [3:0] CELL_ROCK  = 4'b0010;
  localparam logic [3:0] CELL_SNACK = 4'b0100;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [AW-1:0] LAST_IDX  = AW'(CELLS - 1);
  localparam logic [9:0]    SNACK_MAX = 10'(CELLS);

  logic [3:0]    mem_q [CELLS];
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic [9:0]    snack_q, snack_d;
  logic [3:0]    pix_cell_q, pix_cell_d;
  logic [3:0]    clr_val;

  // Controller write command
  logic [15:0]   wr_x, wr_y;
  logic [3:0]    wr_func, wr_old;
  logic          wr_in_range, wr_en;
  logic [AW-1:0] wr_idx;

  assign wr_x        = rect_write[35:20];
  assign wr_y        = rect_write[19:4];
  assign wr_func     = rect_write[3:0];
  assign wr_in_range = (wr_x < 16'(GRID_SIZE_X)) && (wr_y < 16'(GRID_SIZE_Y));
  assign wr_en       = (state_q == ST_IDLE) && wr_in_range;
  assign wr_idx      = AW'(32'(wr_y) * GRID_SIZE_X + 32'(wr_x));
  assign wr_old      = mem_q[wr_idx];

  // Controller query: out-of-grid reads as wall so the snake dies at the edge
  logic [15:0]   rd_x, rd_y;
  logic          rd_in_range;
  logic [AW-1:0] rd_idx;

  assign rd_x        = rect_read_addr[31:16];
  assign rd_y        = rect_read_addr[15:0];
  assign rd_in_range = (rd_x < 16'(GRID_SIZE_X)) && (rd_y < 16'(GRID_SIZE_Y));
  assign rd_idx      = AW'(32'(rd_y) * GRID_SIZE_X + 32'(rd_x));

  always_comb begin
    if (state_q == ST_CLEAR)  rect_read_data = CELL_NULL;
    else if (!rd_in_range)    rect_read_data = CELL_ROCK;
    else                      rect_read_data = mem_q[rd_idx];
  end

  // Renderer lookup
  logic [10:0]   pix_cx, pix_cy;
  logic          pix_in_range;
  logic [AW-1:0] pix_idx;

  assign pix_cx       = pix_x >> RECT_SHIFT;
  assign pix_cy       = pix_y >> RECT_SHIFT;
  assign pix_in_range = (pix_cx < 11'(GRID_SIZE_X)) && (pix_cy < 11'(GRID_SIZE_Y));
  assign pix_idx      = AW'(32'(pix_cy) * GRID_SIZE_X + 32'(pix_cx));
  assign pix_cell_d   = ((state_q == ST_CLEAR) || !pix_in_range) ? CELL_NULL : mem_q[pix_idx];

`ifdef GRID_BORDER_EN
  int clr_x, clr_y;
  always_comb begin
    clr_x   = int'(clr_idx_q) % GRID_SIZE_X;
    clr_y   = int'(clr_idx_q) / GRID_SIZE_X;
    clr_val = CELL_NULL;
    if ((clr_x == 0) || (clr_x == GRID_SIZE_X - 1) || (clr_y == 0) || (clr_y == GRID_SIZE_Y - 1))
      clr_val = CELL_ROCK;
  end
`else
  assign clr_val = CELL_NULL;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    snack_d   = snack_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          if ((wr_old != CELL_SNACK) && (wr_func == CELL_SNACK) && (snack_q != SNACK_MAX))
            snack_d = snack_q + 10'd1;
          else if ((wr_old == CELL_SNACK) && (wr_func != CELL_SNACK) && (snack_q != 10'd0))
            snack_d = snack_q - 10'd1;
        end
        if (clear_req) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      default: begin
        if (clear_req) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == LAST_IDX) begin
          state_d   = ST_IDLE;
          clr_idx_d = '0;
          snack_d   = 10'd0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_idx_q  <= '0;
      snack_q    <= 10'd0;
      pix_cell_q <= CELL_NULL;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      snack_q    <= snack_d;
      pix_cell_q <= pix_cell_d;
    end
  end

  // NOTE: the cell array has no reset; the clearing sweep is what defines its contents.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR)
      mem_q[clr_idx_q] <= clr_val;
    else if (wr_in_range)
      mem_q[wr_idx] <= wr_func;
  end

  assign busy        = (state_q == ST_CLEAR);
  assign pix_cell    = pix_cell_q;
  assign snack_count = snack_q;

endmodule

// File: tb/tb_rect_grid_store.sv
// Self-checking bench for rect_grid_store: vector table for the write/read paths,
// a scoreboard queue for the registered renderer port, and hand sequences for sweep/reset timing.
module tb_rect_grid_store;

  localparam logic [3:0] NUL = 4'b0000, SNK = 4'b0001, RCK = 4'b0010, SNC = 4'b0100;
`ifdef GRID_BORDER_EN
  localparam logic [3:0] BV = RCK;
`else
  localparam logic [3:0] BV = NUL;
`endif
  localparam logic [35:0] NOP = {16'hFFFF, 16'hFFFF, 4'h0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [35:0] rect_write = NOP;
  logic [31:0] rect_read_addr = '0;
  logic [3:0]  rect_read_data;
  logic        clear_req = 1'b0;
  logic        busy;
  logic [10:0] pix_x = '0, pix_y = '0;
  logic [3:0]  pix_cell;
  logic [9:0]  snack_count;

  rect_grid_store dut (
    .clk(clk), .rst_n(rst_n),
    .rect_write(rect_write), .rect_read_addr(rect_read_addr), .rect_read_data(rect_read_data),
    .clear_req(clear_req), .busy(busy),
    .pix_x(pix_x), .pix_y(pix_y), .pix_cell(pix_cell), .snack_count(snack_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [3:0] pix_q[$];

  typedef struct {
    logic [35:0] wr;
    logic [31:0] rd;
    logic [10:0] px, py;
    logic [3:0]  exp_rd;
    logic [3:0]  exp_pix;
    logic [9:0]  exp_snack;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] w(input int x, input int y, input logic [3:0] f);
    return {16'(x), 16'(y), f};
  endfunction

  function automatic logic [31:0] a(input int x, input int y);
    return {16'(x), 16'(y)};
  endfunction

  // Advance one clock; settle 1 ns past the edge and retire one pending renderer expectation.
  task automatic cycle();
    logic [3:0] e;
    @(posedge clk);
    #1;
    if (pix_q.size() > 0) begin
      e = pix_q.pop_front();
      check("pix_cell", {28'd0, pix_cell}, {28'd0, e});
    end
  endtask

  task automatic drive_pix(input int px, input int py, input logic [3:0] e);
    pix_x = 11'(px);
    pix_y = 11'(py);
    pix_q.push_back(e);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (busy && n < 3000);
  endtask

  task automatic hold_write(input logic [35:0] wv, input int n);
    rect_write = wv;
    repeat (n) cycle();
    rect_write = NOP;
  endtask

  initial begin
    int n;
    logic [3:0] e;

    vecs[0]  = '{w(15, 15, SNK), a(15, 15), 11'd480, 11'd480, NUL, NUL, 10'd0};
    vecs[1]  = '{NOP, a(15, 15), 11'd480, 11'd480, SNK, SNK, 10'd0};
    vecs[2]  = '{NOP, a(16'hFFFF, 5), 11'd1023, 11'd100, RCK, BV, 10'd0};
    vecs[3]  = '{w(40, 3, SNK), a(32, 0), 11'd0, 11'd0, RCK, BV, 10'd0};
    vecs[4]  = '{NOP, a(8, 4), 11'd1504, 11'd448, NUL, NUL, 10'd0};
    vecs[5]  = '{NOP, a(16'h100F, 15), 11'd480, 11'd768, RCK, NUL, 10'd0};
    vecs[6]  = '{w(3, 4, SNC), a(3, 4), 11'd96, 11'd128, NUL, NUL, 10'd0};
    vecs[7]  = '{NOP, a(3, 4), 11'd127, 11'd159, SNC, SNC, 10'd1};
    vecs[8]  = '{w(0, 0, RCK), a(31, 23), 11'd992, 11'd736, BV, BV, 10'd1};
    vecs[9]  = '{NOP, a(0, 0), 11'd0, 11'd0, RCK, RCK, 10'd1};
    vecs[10] = '{w(31, 23, 4'hA), a(31, 23), 11'd1000, 11'd740, BV, BV, 10'd1};
    vecs[11] = '{NOP, a(31, 23), 11'd1000, 11'd740, 4'hA, 4'hA, 10'd1};
    vecs[12] = '{w(5, 24, SNK), a(5, 24), 11'd160, 11'd0, RCK, BV, 10'd1};
    vecs[13] = '{NOP, a(16'hFFFF, 16'hFFFF), 11'd2047, 11'd2047, RCK, NUL, 10'd1};

    // Reset state and sweep length
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_pix_cell", {28'd0, pix_cell}, 32'd0);
    check("rst_snack", {22'd0, snack_count}, 32'd0);
    rst_n = 1'b1;
    wait_idle(n);
    check("busy_len_reset", n, 32'd768);
    for (int y = 0; y < 24; y++) begin
      for (int x = 0; x < 32; x++) begin
        rect_read_addr = a(x, y);
        #0.1;
        e = (x == 0 || x == 31 || y == 0 || y == 23) ? BV : NUL;
        check($sformatf("scan_%0d_%0d", x, y), {28'd0, rect_read_data}, {28'd0, e});
      end
    end

    // Table vectors: the combinational read shows the pre-write value within the cycle
    for (int i = 0; i < 14; i++) begin
      rect_write = vecs[i].wr;
      rect_read_addr = vecs[i].rd;
      drive_pix(int'(vecs[i].px), int'(vecs[i].py), vecs[i].exp_pix);
      #4;
      check($sformatf("vec%0d_rd", i), {28'd0, rect_read_data}, {28'd0, vecs[i].exp_rd});
      check($sformatf("vec%0d_snack", i), {22'd0, snack_count}, {22'd0, vecs[i].exp_snack});
      cycle();
    end
    rect_write = NOP;

    // Snack counting: held rewrite is harmless, repeated NULL does not underflow
    hold_write(w(3, 4, SNC), 10);
    #4 check("snack_hold", {22'd0, snack_count}, 32'd1);
    hold_write(w(3, 4, NUL), 3);
    rect_read_addr = a(3, 4);
    #4 check("snack_clear", {22'd0, snack_count}, 32'd0);
    check("rd_3_4_null", {28'd0, rect_read_data}, 32'd0);
    hold_write(w(9, 9, SNC), 1);
    hold_write(w(10, 9, SNC), 1);
    #4 check("snack_two", {22'd0, snack_count}, 32'd2);
    hold_write(w(9, 9, RCK), 1);
    #4 check("snack_rock_over", {22'd0, snack_count}, 32'd1);
    hold_write(w(10, 9, NUL), 1);
    #4 check("snack_zero", {22'd0, snack_count}, 32'd0);

    // Same-cell write and read in one cycle
    cycle();
    rect_write = w(7, 7, SNC);
    rect_read_addr = a(7, 7);
    #4 check("same_cycle_old", {28'd0, rect_read_data}, 32'd0);
    cycle();
    rect_write = NOP;
    #4 check("same_cycle_new", {28'd0, rect_read_data}, {28'd0, SNC});
    check("same_cycle_snack", {22'd0, snack_count}, 32'd1);

    // clear_req, restart at index 400, writes ignored while busy
    cycle();
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    #4 check("clear_busy", {31'd0, busy}, 32'd1);
    repeat (400) cycle();
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    rect_write = w(20, 20, SNK);
    rect_read_addr = a(15, 15);
    drive_pix(480, 480, NUL);
    #4 check("busy_read_null", {28'd0, rect_read_data}, 32'd0);
    repeat (100) cycle();
    rect_write = NOP;
    wait_idle(n);
    check("busy_len_restart", n + 100, 32'd768);
    check("sweep_snack", {22'd0, snack_count}, 32'd0);
    foreach (vecs[i]) begin end
    rect_read_addr = a(20, 20);
    #1 check("busy_write_dropped", {28'd0, rect_read_data}, 32'd0);
    rect_read_addr = a(15, 15);
    #1 check("cleared_15_15", {28'd0, rect_read_data}, 32'd0);
    rect_read_addr = a(7, 7);
    #1 check("cleared_7_7", {28'd0, rect_read_data}, 32'd0);

    // Reset in mid-game
    cycle();
    hold_write(w(2, 2, SNC), 1);
    drive_pix(64, 64, SNC);
    cycle();
    check("pre_reset_snack", {22'd0, snack_count}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midgame_rst_busy", {31'd0, busy}, 32'd1);
    check("midgame_rst_snack", {22'd0, snack_count}, 32'd0);
    check("midgame_rst_pix", {28'd0, pix_cell}, 32'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    wait_idle(n);
    check("busy_len_midgame", n, 32'd768);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
